// File: rtl/fetch_queue_ifetch.sv
// fetch_queue_ifetch: instruction fetch stage with a decoupling fetch queue.
// Issues one 64-bit line request at a time, splits each returned line into
// up to two instructions and buffers them for decode. Redirects from the ROB
// take priority over the branch predictor. A response that is still in flight
// when a redirect arrives is squashed.
// Optional feature macro: FETCH_PERF_EN builds the three performance counters.
// Without it, the perf ports are tied to zero.
package fetch_queue_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] npc;
    logic            valid;
  } if_id_packet_t;
endpackage

module fetch_queue_ifetch
  import fetch_queue_pkg::*;
#(
  parameter int              FETCH_WIDTH = 2,
  parameter int              FQ_DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               rob_target_valid,
  input  logic [XLEN-1:0]                    rob_target_pc,
  input  logic                               branch_predictor_valid,
  input  logic [XLEN-1:0]                    branch_predictor_pc,
  output logic                               proc2Icache_req,
  output logic [XLEN-1:0]                    proc2Icache_addr,
  input  logic [63:0]                        Icache2proc_data,
  input  logic                               Icache2proc_data_valid,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0]   deq_count,
  output if_id_packet_t                      if_packet [FETCH_WIDTH],
  output logic [$clog2(FQ_DEPTH+1)-1:0]      fq_count,
  output logic [31:0]                        perf_fetched,
  output logic [31:0]                        perf_redirects,
  output logic [31:0]                        perf_full_stalls
);

  localparam int PTR_W = $clog2(FQ_DEPTH);
  localparam int CNT_W = $clog2(FQ_DEPTH+1);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t            state_q, state_d;
  logic              squash_q, squash_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  head_q, tail_q, tail_next;
  logic [CNT_W-1:0]  count_q, free_slots, deq_eff, n_enq;
  logic              redirect, enq;
  logic [XLEN-1:0]   line_base, next_line;

  logic [31:0]       inst_mem [FQ_DEPTH];
  logic [XLEN-1:0]   pc_mem   [FQ_DEPTH];

  assign redirect         = rob_target_valid | branch_predictor_valid;
  assign line_base        = {fetch_pc_q[XLEN-1:3], 3'b000};
  assign next_line        = {fetch_pc_q[XLEN-1:3] + (XLEN-3)'(1), 3'b000};
  assign proc2Icache_addr = line_base;
  assign free_slots       = CNT_W'(FQ_DEPTH) - count_q;
  assign tail_next        = tail_q + PTR_W'(1);
  assign fq_count         = count_q;
  // Decode must never take more than the queue holds; clamp so it cannot underflow.
  assign deq_eff          = (CNT_W'(deq_count) > count_q) ? count_q : CNT_W'(deq_count);
  assign n_enq            = !enq ? '0 : (fetch_pc_q[2] ? CNT_W'(1) : CNT_W'(2));

  // Fetch FSM next state: redirect target selection, request, response handling.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d         = state_q;
    squash_d        = squash_q;
    fetch_pc_d      = fetch_pc_q;
    proc2Icache_req = 1'b0;
    enq             = 1'b0;
    if (rob_target_valid)            fetch_pc_d = rob_target_pc;
    else if (branch_predictor_valid) fetch_pc_d = branch_predictor_pc;
    case (state_q)
      IDLE: begin
        // A redirect holds off the request so the new target line goes out next cycle.
        if (!redirect && free_slots >= CNT_W'(2)) begin
          proc2Icache_req = 1'b1;
          state_d         = WAIT;
        end
      end
      WAIT: begin
        if (Icache2proc_data_valid) begin
          state_d  = IDLE;
          squash_d = 1'b0;
          if (!squash_q && !redirect) begin
            enq        = 1'b1;
            fetch_pc_d = next_line;
          end
        end else if (redirect) begin
          squash_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      state_d         = IDLE;
      squash_d        = 1'b0;
      fetch_pc_d      = RESET_PC;
      proc2Icache_req = 1'b0;
      enq             = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    state_q    <= state_d;
    squash_q   <= squash_d;
    fetch_pc_q <= fetch_pc_d;
  end

  // Queue pointers and occupancy; a ROB flush overrides same-cycle enqueue and dequeue.
  always_ff @(posedge clock) begin
    if (reset || rob_target_valid) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(deq_eff);
      tail_q  <= tail_q + PTR_W'(n_enq);
      count_q <= count_q + n_enq - deq_eff;
    end
  end

  // Queue storage writes, in PC order.
  always_ff @(posedge clock) begin
    // NOTE: the storage array has no reset; entries are only read when count_q marks them valid.
    if (enq) begin
      if (fetch_pc_q[2]) begin
        inst_mem[tail_q] <= Icache2proc_data[63:32];
        pc_mem[tail_q]   <= fetch_pc_q;
      end else begin
        inst_mem[tail_q]    <= Icache2proc_data[31:0];
        pc_mem[tail_q]      <= fetch_pc_q;
        inst_mem[tail_next] <= Icache2proc_data[63:32];
        pc_mem[tail_next]   <= {fetch_pc_q[XLEN-1:3], 3'b100};
      end
    end
  end

  // Decode view: oldest entries first; empty slots show a NOP at PC 0.
  always_comb begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (!reset && CNT_W'(i) < count_q) begin
        if_packet[i] = '{inst:  inst_mem[head_q + PTR_W'(i)],
                         pc:    pc_mem[head_q + PTR_W'(i)],
                         npc:   pc_mem[head_q + PTR_W'(i)] + XLEN'(4),
                         valid: 1'b1};
      end else begin
        if_packet[i] = '{inst: NOP, pc: '0, npc: '0, valid: 1'b0};
      end
    end
  end

  // Flag decode over-consuming in simulation; the hardware clamps regardless.
  deq_not_above_count: assert property (@(posedge clock) disable iff (reset)
    (CNT_W'(deq_count) <= count_q));

`ifdef FETCH_PERF_EN
  logic stall;
  assign stall = (state_q == IDLE) && (free_slots < CNT_W'(2));

  // Saturating performance counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched     <= '0;
      perf_redirects   <= '0;
      perf_full_stalls <= '0;
    end else begin
      if (enq)
        perf_fetched <= (perf_fetched > 32'hFFFF_FFFF - 32'(n_enq)) ? 32'hFFFF_FFFF
                                                                     : perf_fetched + 32'(n_enq);
      if (redirect && perf_redirects != 32'hFFFF_FFFF)
        perf_redirects <= perf_redirects + 32'd1;
      if (stall && perf_full_stalls != 32'hFFFF_FFFF)
        perf_full_stalls <= perf_full_stalls + 32'd1;
    end
  end
`else
  assign perf_fetched     = '0;
  assign perf_redirects   = '0;
  assign perf_full_stalls = '0;
`endif

endmodule

// File: tb/tb_fetch_queue_ifetch.sv
// Directed bench for fetch_queue_ifetch (default parameters, RESET_PC=0).
// The I-cache model returns line A as {inst_of(A+4), inst_of(A)}.
module tb_fetch_queue_ifetch;
  import fetch_queue_pkg::*;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rob_target_valid = 1'b0;
  logic [31:0]   rob_target_pc = '0;
  logic          branch_predictor_valid = 1'b0;
  logic [31:0]   branch_predictor_pc = '0;
  logic          proc2Icache_req;
  logic [31:0]   proc2Icache_addr;
  logic [63:0]   Icache2proc_data = '0;
  logic          Icache2proc_data_valid = 1'b0;
  logic [1:0]    deq_count = '0;
  if_id_packet_t if_packet [2];
  logic [3:0]    fq_count;
  logic [31:0]   perf_fetched, perf_redirects, perf_full_stalls;

  int errors = 0;
  int checks = 0;

  fetch_queue_ifetch dut (
    .clock                  (clock),
    .reset                  (reset),
    .rob_target_valid       (rob_target_valid),
    .rob_target_pc          (rob_target_pc),
    .branch_predictor_valid (branch_predictor_valid),
    .branch_predictor_pc    (branch_predictor_pc),
    .proc2Icache_req        (proc2Icache_req),
    .proc2Icache_addr       (proc2Icache_addr),
    .Icache2proc_data       (Icache2proc_data),
    .Icache2proc_data_valid (Icache2proc_data_valid),
    .deq_count              (deq_count),
    .if_packet              (if_packet),
    .fq_count               (fq_count),
    .perf_fetched           (perf_fetched),
    .perf_redirects         (perf_redirects),
    .perf_full_stalls       (perf_full_stalls)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  function automatic logic [63:0] line_of(input logic [31:0] addr);
    return {inst_of(addr + 32'd4), inst_of(addr)};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_slot(input string tag, input int i, input logic [31:0] pc);
    check({tag, "_valid"}, 32'(if_packet[i].valid), 32'd1);
    check({tag, "_pc"},    if_packet[i].pc,   pc);
    check({tag, "_inst"},  if_packet[i].inst, inst_of(pc));
  endtask

  task automatic check_empty_slot(input string tag, input int i);
    check({tag, "_valid"}, 32'(if_packet[i].valid), 32'd0);
    check({tag, "_inst"},  if_packet[i].inst, 32'h0000_0013);
    check({tag, "_pc"},    if_packet[i].pc,   32'd0);
  endtask

  // Wait (bounded) for a request, check its address, then answer one cycle later.
  task automatic fetch_one(input logic [31:0] addr, input string tag);
    int n = 0;
    #1;
    while (!proc2Icache_req && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req"},  32'(proc2Icache_req), 32'd1);
    check({tag, "_addr"}, proc2Icache_addr, addr);
    step();
    Icache2proc_data       = line_of(addr);
    Icache2proc_data_valid = 1'b1;
    step();
    Icache2proc_data_valid = 1'b0;
  endtask

  initial begin
    int          n;
    logic        pending;
    logic [31:0] exp_pc, exp_line;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_req", 32'(proc2Icache_req), 32'd0);
    check("rst_count", 32'(fq_count), 32'd0);
    check_empty_slot("rst_s0", 0);
    check_empty_slot("rst_s1", 1);
    check("rst_perf_f", perf_fetched, 32'd0);
    reset = 1'b0;

    // Sequential fill to full
    fetch_one(32'h00, "l00");
    check("fill_cnt2", 32'(fq_count), 32'd2);
    fetch_one(32'h08, "l08");
    fetch_one(32'h10, "l10");
    check("fill_cnt6", 32'(fq_count), 32'd6);
    check_slot("fill_s0", 0, 32'h00);
    check_slot("fill_s1", 1, 32'h04);
    check("fill_npc", if_packet[1].npc, 32'h08);
    fetch_one(32'h18, "l18");
    check("fill_cnt8", 32'(fq_count), 32'd8);
    for (int c = 0; c < 3; c++) begin
      check("full_no_req", 32'(proc2Icache_req), 32'd0);
      step();
    end
`ifdef FETCH_PERF_EN
    check("perf_fetched8", perf_fetched, 32'd8);
    check("perf_stalls3", perf_full_stalls, 32'd3);
    check("perf_redir0", perf_redirects, 32'd0);
`else
    check("perf_fetched0", perf_fetched, 32'd0);
    check("perf_stalls0", perf_full_stalls, 32'd0);
`endif

    // Predictor redirect to 0x104 while IDLE
    branch_predictor_valid = 1'b1;
    branch_predictor_pc    = 32'h104;
    #1;
    check("bp_req_low", 32'(proc2Icache_req), 32'd0);
    step();
    branch_predictor_valid = 1'b0;
    deq_count = 2'd2;
    #1;
    check_slot("bp_d0", 0, 32'h00);
    check_slot("bp_d1", 1, 32'h04);
    step();
    deq_count = 2'd0;
    fetch_one(32'h100, "l100");
    check("bp_cnt7", 32'(fq_count), 32'd7);
    check_slot("bp_keep", 0, 32'h08);
    deq_count = 2'd2;
    #1;
    check_slot("dA0", 0, 32'h08);
    check_slot("dA1", 1, 32'h0C);
    step();
    check_slot("dB0", 0, 32'h10);
    check_slot("dB1", 1, 32'h14);
    check("dB_req", 32'(proc2Icache_req), 32'd1);
    check("dB_addr", proc2Icache_addr, 32'h108);
    step();
    Icache2proc_data       = line_of(32'h108);
    Icache2proc_data_valid = 1'b1;
    #1;
    check_slot("dC0", 0, 32'h18);
    check_slot("dC1", 1, 32'h1C);
    step();
    Icache2proc_data_valid = 1'b0;
    #1;
    check("dD_cnt", 32'(fq_count), 32'd3);
    check_slot("dD0", 0, 32'h104);
    check_slot("dD1", 1, 32'h108);
    check("dD_addr", proc2Icache_addr, 32'h110);
    step();
    deq_count = 2'd0;
    #1;
    check("dE_cnt", 32'(fq_count), 32'd1);
    check_slot("dE0", 0, 32'h10C);
    check_empty_slot("dE1", 1);

    // ROB + predictor + response in WAIT
    rob_target_valid       = 1'b1;
    rob_target_pc          = 32'h200;
    branch_predictor_valid = 1'b1;
    branch_predictor_pc    = 32'h300;
    Icache2proc_data       = line_of(32'h110);
    Icache2proc_data_valid = 1'b1;
    #1;
    check("rob_wait_req", 32'(proc2Icache_req), 32'd0);
    step();
    rob_target_valid       = 1'b0;
    branch_predictor_valid = 1'b0;
    Icache2proc_data_valid = 1'b0;
    #1;
    check("rob_cnt0", 32'(fq_count), 32'd0);
    check_empty_slot("rob_s0", 0);
    check("rob_req", 32'(proc2Icache_req), 32'd1);
    check("rob_addr", proc2Icache_addr, 32'h200);
`ifdef FETCH_PERF_EN
    check("perf_redir2", perf_redirects, 32'd2);
`endif

    // Redirect in WAIT with the response three cycles later
    step();
    branch_predictor_valid = 1'b1;
    branch_predictor_pc    = 32'h404;
    #1;
    check("late_req_g", 32'(proc2Icache_req), 32'd0);
    step();
    branch_predictor_valid = 1'b0;
    #1;
    check("late_req_h", 32'(proc2Icache_req), 32'd0);
    step();
    check("late_req_i", 32'(proc2Icache_req), 32'd0);
    step();
    Icache2proc_data       = line_of(32'h200);
    Icache2proc_data_valid = 1'b1;
    step();
    Icache2proc_data_valid = 1'b0;
    #1;
    check("late_cnt0", 32'(fq_count), 32'd0);
    check("late_addr", proc2Icache_addr, 32'h400);
    fetch_one(32'h400, "l400");
    check("late_cnt1", 32'(fq_count), 32'd1);
    check_slot("late_s0", 0, 32'h404);

    // Streaming with deq_count up to 2 and pointer wrap
    fetch_one(32'h408, "l408");
    fetch_one(32'h410, "l410");
    check("st_cnt5", 32'(fq_count), 32'd5);
    pending  = 1'b0;
    exp_pc   = 32'h404;
    exp_line = 32'h418;
    for (int c = 0; c < 40; c++) begin
      Icache2proc_data_valid = pending;
      Icache2proc_data       = line_of(exp_line - 32'd8);
      n = (fq_count > 4'd2) ? 2 : int'(fq_count);
      deq_count = 2'(n);
      #1;
      for (int i = 0; i < n; i++) begin
        check_slot("st_slot", i, exp_pc);
        exp_pc += 32'd4;
      end
      check("st_le8", 32'(fq_count <= 4'd8), 32'd1);
      pending = proc2Icache_req;
      if (proc2Icache_req) begin
        check("st_addr", proc2Icache_addr, exp_line);
        exp_line += 32'd8;
      end
      step();
    end
    deq_count              = 2'd0;
    Icache2proc_data_valid = 1'b0;
    check("st_progress", 32'(exp_pc > 32'h460), 32'd1);

`ifndef FETCH_PERF_EN
    check("end_perf_f", perf_fetched, 32'd0);
    check("end_perf_r", perf_redirects, 32'd0);
    check("end_perf_s", perf_full_stalls, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
